// File: rtl/ram_arb.sv
// ram_arb: two-master arbiter onto one single-port RAM (IDLE -> ACCESS -> RESP).
// Define RAM_ARB_RR_EN for round-robin IDLE arbitration; default is fixed priority to m0.
module ram_arb #(
    parameter int XLEN         = 32,
    parameter int RAM_ADDR_LEN = 14
) (
    input  logic                    clk,
    input  logic                    rstb_in,
    input  logic                    m0_req,
    input  logic [XLEN/8-1:0]       m0_we,
    input  logic [RAM_ADDR_LEN-1:0] m0_addr,
    input  logic [XLEN-1:0]         m0_wdata,
    output logic                    m0_ready,
    output logic [XLEN-1:0]         m0_rdata,
    input  logic                    m1_req,
    input  logic [XLEN/8-1:0]       m1_we,
    input  logic [RAM_ADDR_LEN-1:0] m1_addr,
    input  logic [XLEN-1:0]         m1_wdata,
    output logic                    m1_ready,
    output logic [XLEN-1:0]         m1_rdata,
    output logic                    ram_en,
    output logic [XLEN/8-1:0]       ram_we,
    output logic [RAM_ADDR_LEN-1:0] ram_addr,
    output logic [XLEN-1:0]         ram_wr_data,
    input  logic [XLEN-1:0]         ram_rd_data
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
    logic [1:0] state_q, state_d;
    logic       gnt_q, gnt_d, last_gnt_q, last_gnt_d;
    logic       win, other_req, access, resp;
`ifdef RAM_ARB_RR_EN
    assign win = (m0_req & m1_req) ? ~last_gnt_q : m1_req;
`else
    // last_gnt only matters with no request pending, when the grant is not taken
    assign win = ~m0_req & (m1_req | last_gnt_q);
`endif
    assign other_req = gnt_q ? m0_req : m1_req;
    assign access    = state_q == ACCESS;
    assign resp      = state_q == RESP;
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        if (state_q == IDLE) begin
            state_d = (m0_req | m1_req) ? ACCESS : IDLE;
            gnt_d   = (m0_req | m1_req) ? win : gnt_q;
        end else if (access) begin
            state_d = RESP;
        end else if (resp) begin
            last_gnt_d = gnt_q;
            state_d    = other_req ? ACCESS : IDLE;
            gnt_d      = other_req ? ~gnt_q : gnt_q;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rstb_in) begin
        if (!rstb_in) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end
    assign ram_en      = access;
    assign ram_we      = access ? (gnt_q ? m1_we : m0_we) : '0;
    assign ram_addr    = access ? (gnt_q ? m1_addr : m0_addr) : '0;
    assign ram_wr_data = access ? (gnt_q ? m1_wdata : m0_wdata) : '0;
    assign m0_ready    = resp & ~gnt_q;
    assign m1_ready    = resp & gnt_q;
    assign m0_rdata    = ram_rd_data;
    assign m1_rdata    = ram_rd_data;
endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32, data bus width in bits.
REQ-002 The block SHALL provide parameter RAM_ADDR_LEN, default 14, RAM word-address width.
REQ-003 The block SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstb_in, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports m0_req, input, 1 and m1_req, input, 1, per-master access request.
REQ-006 The block SHALL have ports m0_we, input, XLEN/8 and m1_we, input, XLEN/8, per-master byte write enables; all-zero means read.
REQ-007 The block SHALL have ports m0_addr, input, RAM_ADDR_LEN and m1_addr, input, RAM_ADDR_LEN, per-master word address.
REQ-008 The block SHALL have ports m0_wdata, input, XLEN and m1_wdata, input, XLEN, per-master write data.
REQ-009 The block SHALL have ports m0_ready, output, 1 and m1_ready, output, 1, per-master one-cycle completion strobe.
REQ-010 The block SHALL have ports m0_rdata, output, XLEN and m1_rdata, output, XLEN, per-master read data.
REQ-011 The block SHALL have ports ram_en, output, 1; ram_we, output, XLEN/8; ram_addr, output, RAM_ADDR_LEN; ram_wr_data, output, XLEN. These drive the single RAM port.
REQ-012 The block SHALL have port ram_rd_data, input, XLEN, RAM read data with 1-cycle latency after ram_en.

Function
REQ-013 The block SHALL implement the FSM states IDLE, ACCESS and RESP, plus a registered grant bit gnt (0 selects m0, 1 selects m1) and a registered bit last_gnt.
REQ-014 In IDLE, if any mX_req is high, the FSM SHALL latch the winner into gnt and move to ACCESS; otherwise it SHALL remain in IDLE.
REQ-015 In ACCESS, the block SHALL assert ram_en=1 and drive ram_we, ram_addr and ram_wr_data from the granted master's inputs, then move to RESP.
REQ-016 In RESP, the block SHALL assert the granted master's mX_ready for exactly one cycle, with mX_rdata = ram_rd_data.
REQ-017 On leaving RESP, the FSM SHALL set last_gnt=gnt.
REQ-018 On leaving RESP, if the non-granted master's req is high, the FSM SHALL set gnt to that master and go directly to ACCESS; otherwise it SHALL go to IDLE.
REQ-019 Outside ACCESS, ram_en SHALL be 0 and ram_we SHALL be 0.
REQ-020 Outside RESP, both mX_ready outputs SHALL be 0.
REQ-021 The non-granted master's mX_rdata value is don't-care, and mX_rdata following a write is don't-care.
REQ-022 Access latency SHALL be exactly 2 cycles from the IDLE cycle in which req is sampled to the ready cycle; ready therefore appears in the third cycle.
REQ-023 Requesters SHALL hold req, we, addr and wdata stable until their ready. A requester may present a new request in the cycle after its ready. The block does not check for protocol violations.
REQ-024 A req deasserted while that master is not granted SHALL be treated as withdrawn, with no RAM access.
REQ-025 A master SHALL never be granted twice in a row while the other master's req is continuously high.
REQ-026 Sustained throughput SHALL be one access per 3 cycles for a single master, and one access per 2 cycles while both masters alternate.

Reset
REQ-027 On rstb_in low, the block SHALL asynchronously set state=IDLE, gnt=0, last_gnt=1, ram_en=0, ram_we=0, m0_ready=0 and m1_ready=0.
REQ-028 ram_addr and ram_wr_data SHALL reset to 0.
REQ-029 A reset asserted during ACCESS or RESP SHALL drop the in-flight access. No ready strobe is issued for it. A write already clocked into the RAM is not undone.
REQ-030 After rstb_in is released, the first grant SHALL follow the normal IDLE arbitration rule.

Configuration
REQ-031 Macro RAM_ARB_RR_EN SHALL select the IDLE arbitration policy.
REQ-032 With RAM_ARB_RR_EN defined, when both reqs are high in IDLE, the winner SHALL be !last_gnt (round-robin). Out of reset m0 wins, because last_gnt=1.
REQ-033 Without RAM_ARB_RR_EN, when both reqs are high in IDLE, m0 SHALL always win (fixed priority). The RESP hand-over rule in REQ-018 is unchanged.

Verification
REQ-034 Single read: preload RAM[0x0010]=0xDEADBEEF; m0 read addr 0x0010 -> ram_en pulses once in cycle 2; m0_ready in cycle 3 with m0_rdata=0xDEADBEEF; m1_ready stays 0.
REQ-035 Byte write: m1 write addr 0x0004, we=4'b0010, wdata=0x0000AB00, over prior value 0x11223344 -> ram_we=4'b0010 in ACCESS; a following m1 read returns 0x1122AB44.
REQ-036 Contention: m0 and m1 reads raised in the same IDLE cycle to addrs 0x1 and 0x2 -> m0 granted first. m1 goes to ACCESS directly after m0's RESP. ready strobes land in cycles 3 and 5.
REQ-037 Sustained contention: both reqs held for 8 accesses -> with RAM_ARB_RR_EN, grants alternate m0,m1,m0,...; without the macro, the same alternation occurs because of the RESP hand-over. A separate IDLE-entry test with last_gnt=0 and both reqs high -> RR picks m1, fixed priority picks m0.
REQ-038 Reset mid-access: assert rstb_in during ACCESS of an m0 read -> no m0_ready; ram_en=0 immediately; after release, a new m1 request completes normally in 3 cycles.
REQ-039 Withdrawn request: m1_req pulsed high for one cycle while m0 is in ACCESS -> no m1 grant, no ram_en for m1's address, FSM returns to IDLE after m0's RESP.
